// File: rtl/store_merge_unit_pkg.sv
// Shared store/load size encodings, FSM state type and request payload.
package store_merge_unit_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam int unsigned DATA_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      MERGE = 3'd2,
      WRITE = 3'd3,
      ERR   = 3'd4
   } state_t;

   // Captured store request (word address is held separately since its width is a parameter)
   typedef struct packed {
      logic [DATA_W-1:0] wdata;
      logic [1:0]        size;
      logic [1:0]        off;
   } store_req_t;

   // Misaligned half/word or reserved size: the request is refused without touching RAM
   function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/store_merge_unit_byte_lane_merge.sv
// Little-endian lane merge: overwrite only the lanes a store targets.
module byte_lane_merge
   import store_merge_unit_pkg::*;
(
   input  logic [DATA_W-1:0] old_word,
   input  logic [DATA_W-1:0] new_data,
   input  logic [1:0]        size,
   input  logic [1:0]        off,
   output logic [DATA_W-1:0] merged_c
);

   // Start from the old word, then replace the target lanes with the right-aligned store data
   always_comb begin
      merged_c = old_word;
      case (size)
         SZ_BYTE: merged_c[{off, 3'b000} +: 8]        = new_data[7:0];
         SZ_HALF: merged_c[{off[1], 4'b0000} +: 16]   = new_data[15:0];
         SZ_WORD: merged_c                            = new_data;
         default: merged_c                            = old_word;
      endcase
   end

endmodule

// File: rtl/store_merge_unit.sv
// Narrows register stores to byte/half/word on a word-write-only RAM via read-modify-write.
module store_merge_unit
   import store_merge_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_size,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              done,
   output logic              err
);

   state_t            state_q, state_d;
   store_req_t        req_q, req_d;
   logic              ready_d, en_d, we_d, done_d, err_d;
   logic [ADDR_W-1:0] addr_d;
   logic [31:0]       wdata_d;
   logic [31:0]       merged_c;
   logic              unused_addr_hi;

   // Address bits above the RAM range are deliberately dropped
   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

   byte_lane_merge u_merge (
      .old_word (mem_rdata),
      .new_data (req_q.wdata),
      .size     (req_q.size),
      .off      (req_q.off),
      .merged_c (merged_c)
   );

   // Next state and next registered outputs; outputs are computed for the state being entered
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      ready_d = 1'b0;
      en_d    = 1'b0;
      we_d    = 1'b0;
      addr_d  = mem_addr;
      wdata_d = mem_wdata;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            ready_d = 1'b1;
            if (req_valid && req_ready) begin
               ready_d = 1'b0;
               req_d   = '{wdata: req_wdata, size: req_size, off: req_addr[1:0]};
               addr_d  = req_addr[ADDR_W+1:2];
               if (is_bad_req(req_size, req_addr[1:0])) begin
                  state_d = ERR;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
               end else if (req_size == SZ_WORD) begin
                  state_d = WRITE;
                  en_d    = 1'b1;
                  we_d    = 1'b1;
                  wdata_d = req_wdata;
                  done_d  = 1'b1;
               end else begin
                  state_d = READ;
                  en_d    = 1'b1;
               end
            end
         end
         READ: begin
            state_d = MERGE;
         end
         MERGE: begin
            state_d = WRITE;
            en_d    = 1'b1;
            we_d    = 1'b1;
            wdata_d = merged_c;
            done_d  = 1'b1;
         end
         WRITE, ERR: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end

   // State, captured request and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         req_q     <= '0;
         req_ready <= 1'b1;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         req_ready <= ready_d;
         mem_en    <= en_d;
         mem_we    <= we_d;
         mem_addr  <= addr_d;
         mem_wdata <= wdata_d;
         done      <= done_d;
         err       <= err_d;
      end
   end

endmodule
